// File: rtl/life_board_engine_if.sv
// life_board_engine_if
// Bundles the request/display signals between the board engine and its
// controller (edit/step requests, display read port, status outputs).
//   master : controller side (drives requests and display coordinates)
//   slave  : engine side (returns cell_state, busy, step_done, gen_count)
// Also provides the default encoding for `MODE_EDIT (mode value that enables edits).

`ifndef MODE_EDIT
`define MODE_EDIT 1'b1
`endif

interface life_board_engine_if #(
    parameter int K     = 6,
    parameter int GEN_W = 16
);
    logic             mode;
    logic [K-1:0]     cur_x;
    logic [K-1:0]     cur_y;
    logic             toggle_req;
    logic             clear_req;
    logic             step_req;
    logic [K-1:0]     cell_x;
    logic [K-1:0]     cell_y;
    logic             cell_state;
    logic             busy;
    logic             step_done;
    logic [GEN_W-1:0] gen_count;

    modport master (
        output mode, cur_x, cur_y, toggle_req, clear_req, step_req, cell_x, cell_y,
        input  cell_state, busy, step_done, gen_count
    );

    modport slave (
        input  mode, cur_x, cur_y, toggle_req, clear_req, step_req, cell_x, cell_y,
        output cell_state, busy, step_done, gen_count
    );
endinterface

// File: rtl/life_board_engine.sv
// life_board_engine
// Game-of-Life board held as two 2^K x 2^K bit planes. The front plane is
// displayed and edited; the back plane is filled one cell per clock by a
// scan FSM (IDLE -> SCAN -> SWAP), after which the planes swap roles.
// Ports:
//   clk  : system clock
//   rst  : asynchronous reset, active low
//   bus  : life_board_engine_if.slave (edit/step requests, display read,
//          busy / step_done / gen_count status)
// Build option: define LIFE_TORUS_WRAP_EN for a toroidal board; otherwise
// neighbours beyond the border count as dead.

`ifndef MODE_EDIT
`define MODE_EDIT 1'b1
`endif

module life_board_engine #(
    parameter int K     = 6,
    parameter int GEN_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    life_board_engine_if.slave   bus
);
    localparam int AW    = 2 * K;
    localparam int CELLS = 1 << AW;
    localparam logic [K-1:0] CMAX = '1;

    typedef enum logic [1:0] {IDLE, SCAN, SWAP} state_t;

    state_t           state;
    logic [CELLS-1:0] plane0, plane1;
    logic             ptr;          // 0: plane0 is front, 1: plane1 is front
    logic [AW-1:0]    idx;
    logic             busy_r, done_r;
    logic [GEN_W-1:0] gen_r;

    logic [CELLS-1:0] front;
    assign front = ptr ? plane1 : plane0;

    // Display always reads the front plane, so it is stable during SCAN.
    assign bus.cell_state = front[{bus.cell_y, bus.cell_x}];
    assign bus.busy       = busy_r;
    assign bus.step_done  = done_r;
    assign bus.gen_count  = gen_r;

    // Neighbourhood of the scan cell. Index 0/1/2 = coordinate -1/0/+1;
    // K-bit arithmetic wraps naturally, the *_ok flags mask the border
    // when the board is bounded.
    logic [K-1:0]        sx, sy;
    logic [2:0][K-1:0]   nx, ny;
    logic [2:0]          nx_ok, ny_ok;
    logic [3:0]          n;
    logic                next_cell;

    assign sx = idx[K-1:0];
    assign sy = idx[AW-1:K];

    always_comb begin
        nx[0] = sx - K'(1);
        nx[1] = sx;
        nx[2] = sx + K'(1);
        ny[0] = sy - K'(1);
        ny[1] = sy;
        ny[2] = sy + K'(1);
`ifdef LIFE_TORUS_WRAP_EN
        nx_ok = 3'b111;
        ny_ok = 3'b111;
`else
        nx_ok = {sx != CMAX, 1'b1, sx != '0};
        ny_ok = {sy != CMAX, 1'b1, sy != '0};
`endif
        n = '0;
        for (int j = 0; j < 3; j++) begin
            for (int i = 0; i < 3; i++) begin
                if (!(i == 1 && j == 1) && nx_ok[i] && ny_ok[j])
                    n = n + {3'b000, front[{ny[j], nx[i]}]};
            end
        end
        // B3/S23
        next_cell = (n == 4'd3) | (front[idx] & (n == 4'd2));
    end

    logic [AW-1:0] cur_addr;
    logic          edit_mode;
    assign cur_addr  = {bus.cur_y, bus.cur_x};
    assign edit_mode = (bus.mode == `MODE_EDIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            plane0 <= '0;
            plane1 <= '0;
            ptr    <= 1'b0;
            idx    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            gen_r  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Priority clear > step > toggle; losers are dropped.
                    if (bus.clear_req) begin
                        if (ptr) plane1 <= '0;
                        else     plane0 <= '0;
                        gen_r <= '0;
                    end else if (bus.step_req && !edit_mode) begin
                        state  <= SCAN;
                        idx    <= '0;
                        busy_r <= 1'b1;
                    end else if (bus.toggle_req && edit_mode) begin
                        if (ptr) plane1[cur_addr] <= ~plane1[cur_addr];
                        else     plane0[cur_addr] <= ~plane0[cur_addr];
                    end
                end
                SCAN: begin
                    if (ptr) plane0[idx] <= next_cell;
                    else     plane1[idx] <= next_cell;
                    if (idx == '1) begin
                        state  <= SWAP;
                        done_r <= 1'b1;   // high for the SWAP cycle
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                SWAP: begin
                    ptr    <= ~ptr;
                    gen_r  <= gen_r + 1'b1;
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
